// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Module      : button_pkg
// Description : Shared defaults and width helper for the push-button
//               conditioner and its per-channel debounce slice.
// Revision    : 1.0 - initial release
// ============================================================================
package button_pkg;

    localparam int unsigned c_CLK_FREQ_HZ    = 125_000_000;
    localparam int unsigned c_SAMPLE_CNT_MAX = 62_500;
    localparam int unsigned c_PULSE_CNT_MAX  = 200;
    localparam int unsigned c_REPEAT_CYCLES  = 62_500_000;

    // Bits needed to hold values 0..v-1, never less than one.
    function automatic int unsigned clog2w(input int unsigned v);
        int unsigned w;
        w = 1;
        while ((64'd1 << w) < 64'(v)) w = w + 1;
        return w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debounce_bit.sv
`default_nettype none
// ============================================================================
// Module      : button_debounce_bit
// Description : One button channel: 2-flop synchronizer, saturating debounce
//               counter, registered level and rising-edge pulse. Optional
//               auto-repeat when BUTTON_AUTOREPEAT_EN is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debounce_bit
    import button_pkg::*;
#(
    parameter int unsigned PULSE_CNT_MAX = c_PULSE_CNT_MAX,
    parameter int unsigned REPEAT_CYCLES = c_REPEAT_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic i_button,
    input  logic i_sample_tick,
    output logic o_level,
    output logic o_pulse
);

    localparam int unsigned             c_CNT_W   = clog2w(PULSE_CNT_MAX + 1);
    localparam logic [c_CNT_W-1:0]      c_CNT_SAT = c_CNT_W'(PULSE_CNT_MAX);

    logic               r_meta;
    logic               r_sync;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic               r_level;
    logic               r_level_prev;
    logic               r_pulse;
    logic               w_repeat_fire;

    always_comb begin
        w_cnt_next = r_cnt;
        if (!r_sync)
            w_cnt_next = '0;
        else if (i_sample_tick && (r_cnt < c_CNT_SAT))
            w_cnt_next = r_cnt + c_CNT_W'(1);
    end

    // Level is taken from the next count so a release clears it on the
    // same edge that clears the counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta       <= 1'b0;
            r_sync       <= 1'b0;
            r_cnt        <= '0;
            r_level      <= 1'b0;
            r_level_prev <= 1'b0;
            r_pulse      <= 1'b0;
        end else begin
            r_meta       <= i_button;
            r_sync       <= r_meta;
            r_cnt        <= w_cnt_next;
            r_level      <= (w_cnt_next == c_CNT_SAT);
            r_level_prev <= r_level;
            r_pulse      <= (r_level & ~r_level_prev) | w_repeat_fire;
        end
    end

`ifdef BUTTON_AUTOREPEAT_EN
    localparam int unsigned        c_REP_W    = clog2w(REPEAT_CYCLES);
    localparam logic [c_REP_W-1:0] c_REP_LAST = c_REP_W'(REPEAT_CYCLES - 1);

    logic [c_REP_W-1:0] r_rep_cnt;

    // Counting starts on the edge-pulse cycle, so the first repeat lands
    // exactly REPEAT_CYCLES after it.
    always_ff @(posedge clk) begin
        if (rst || !r_level)
            r_rep_cnt <= '0;
        else if (r_level_prev)
            r_rep_cnt <= (r_rep_cnt == c_REP_LAST) ? '0 : r_rep_cnt + c_REP_W'(1);
    end

    assign w_repeat_fire = r_level & r_level_prev & (r_rep_cnt == c_REP_LAST);
`else
    assign w_repeat_fire = (REPEAT_CYCLES == 0) & 1'b0;
`endif

    assign o_level = r_level;
    assign o_pulse = r_pulse;

endmodule
`default_nettype wire

// File: rtl/button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : button_conditioner
// Description : Turns WIDTH raw bouncy buttons into debounced levels and
//               one-cycle press pulses. Optional auto-repeat: BUTTON_AUTOREPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module button_conditioner
    import button_pkg::*;
#(
    parameter int unsigned WIDTH          = 4,
    parameter int unsigned SAMPLE_CNT_MAX = c_SAMPLE_CNT_MAX,
    parameter int unsigned PULSE_CNT_MAX  = c_PULSE_CNT_MAX,
    parameter int unsigned REPEAT_CYCLES  = c_REPEAT_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] buttons_in,
    output logic [WIDTH-1:0] buttons_level,
    output logic [WIDTH-1:0] buttons_pulse
);

    localparam int unsigned        c_TMR_W    = clog2w(SAMPLE_CNT_MAX);
    localparam logic [c_TMR_W-1:0] c_TMR_LAST = c_TMR_W'(SAMPLE_CNT_MAX - 1);

    logic [c_TMR_W-1:0] r_sample_cnt;
    logic               w_sample_tick;

    assign w_sample_tick = (r_sample_cnt == c_TMR_LAST);

    // Free-running sample timer shared by every channel.
    always_ff @(posedge clk) begin
        if (rst || w_sample_tick)
            r_sample_cnt <= '0;
        else
            r_sample_cnt <= r_sample_cnt + c_TMR_W'(1);
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_chan
        button_debounce_bit #(
            .PULSE_CNT_MAX (PULSE_CNT_MAX),
            .REPEAT_CYCLES (REPEAT_CYCLES)
        ) u_bit (
            .clk           (clk),
            .rst           (rst),
            .i_button      (buttons_in[g]),
            .i_sample_tick (w_sample_tick),
            .o_level       (buttons_level[g]),
            .o_pulse       (buttons_pulse[g])
        );
    end

endmodule
`default_nettype wire

// File: tb/tb_button_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_button_conditioner
// Description : Directed self-checking bench for button_conditioner
//               (WIDTH=4, SAMPLE_CNT_MAX=4, PULSE_CNT_MAX=3, REPEAT_CYCLES=20).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_button_conditioner;

    logic       clk;
    logic       rst;
    logic [3:0] r_btn;
    logic [3:0] w_level;
    logic [3:0] w_pulse;

    int total = 0;
    int bad   = 0;

`ifdef BUTTON_AUTOREPEAT_EN
    localparam bit c_AUTOREPEAT = 1'b1;
`else
    localparam bit c_AUTOREPEAT = 1'b0;
`endif

    button_conditioner #(
        .WIDTH          (4),
        .SAMPLE_CNT_MAX (4),
        .PULSE_CNT_MAX  (3),
        .REPEAT_CYCLES  (20)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .buttons_in    (r_btn),
        .buttons_level (w_level),
        .buttons_pulse (w_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] btn;
        logic [3:0] exp_level;
        logic [3:0] exp_pulse;
    } vec_t;

    vec_t vecs[6];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        total++;
        if (act < lo || act > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
        end
    endtask

    // Steps until any masked pulse bit is seen; k = edges taken, -1 on timeout.
    task automatic wait_pulse(input logic [3:0] mask, output int k, output logic [3:0] p);
        k = -1;
        p = '0;
        for (int i = 1; i <= 25; i++) begin
            step();
            if ((w_pulse & mask) != 4'b0000) begin
                k = i;
                p = w_pulse;
                break;
            end
        end
    endtask

    initial begin
        int         k;
        logic [3:0] p;

        vecs[0] = '{1'b1, 4'b1111, 4'b0000, 4'b0000};
        vecs[1] = '{1'b1, 4'b1111, 4'b0000, 4'b0000};
        vecs[2] = '{1'b1, 4'b1111, 4'b0000, 4'b0000};
        vecs[3] = '{1'b0, 4'b0000, 4'b0000, 4'b0000};
        vecs[4] = '{1'b0, 4'b0000, 4'b0000, 4'b0000};
        vecs[5] = '{1'b0, 4'b0000, 4'b0000, 4'b0000};

        rst   = 1'b1;
        r_btn = 4'b1111;
        #1;

        // Reset with all buttons high, then idle
        for (int i = 0; i < 6; i++) begin
            rst   = vecs[i].rst;
            r_btn = vecs[i].btn;
            step();
            check($sformatf("reset_vec%0d_level", i), w_level, vecs[i].exp_level);
            check($sformatf("reset_vec%0d_pulse", i), w_pulse, vecs[i].exp_pulse);
        end

        // Clean press on bit 2
        r_btn = 4'b0100;
        wait_pulse(4'b1111, k, p);
        check("press2_pulse", p, 4'b0100);
        check_range("press2_latency", k, 12, 16);
        for (int i = 0; i < 15; i++) begin
            step();
            check("press2_quiet_pulse", w_pulse, 4'b0000);
            check("press2_level", w_level, 4'b0100);
        end

        // Release bit 2: level holds two cycles, drops on the third
        r_btn = 4'b0000;
        step();
        check("release_f1_level", w_level, 4'b0100);
        check("release_f1_pulse", w_pulse, 4'b0000);
        step();
        check("release_f2_level", w_level, 4'b0100);
        check("release_f2_pulse", w_pulse, 4'b0000);
        step();
        check("release_f3_level", w_level, 4'b0000);
        check("release_f3_pulse", w_pulse, 4'b0000);
        for (int i = 0; i < 4; i++) begin
            step();
            check("release_idle_pulse", w_pulse, 4'b0000);
        end

        // Bounce on bit 1: toggles every 2 cycles, never debounces
        for (int i = 0; i < 40; i++) begin
            r_btn = {2'b00, 1'((i / 2) % 2), 1'b0};
            step();
            check("bounce_level", w_level, 4'b0000);
            check("bounce_pulse", w_pulse, 4'b0000);
        end
        r_btn = 4'b0000;
        for (int i = 0; i < 6; i++) begin
            step();
            check("bounce_after_level", w_level, 4'b0000);
            check("bounce_after_pulse", w_pulse, 4'b0000);
        end

        // Simultaneous press on bits 3 and 0
        r_btn = 4'b1001;
        wait_pulse(4'b1111, k, p);
        check("simul_pulse", p, 4'b1001);
        check_range("simul_latency", k, 12, 16);
        step();
        check("simul_pulse_next", w_pulse, 4'b0000);
        check("simul_level", w_level, 4'b1001);
        r_btn = 4'b0000;
        for (int i = 0; i < 5; i++) step();
        check("simul_released_level", w_level, 4'b0000);

        // Reset while bit 2 is held
        r_btn = 4'b0100;
        wait_pulse(4'b0100, k, p);
        check("hold_first_pulse", p, 4'b0100);
        for (int i = 0; i < 5; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("midrst_level", w_level, 4'b0000);
        check("midrst_pulse", w_pulse, 4'b0000);
        wait_pulse(4'b1111, k, p);
        check("midrst_second_pulse", p, 4'b0100);
        check_range("midrst_latency", k, 12, 16);
        r_btn = 4'b0000;
        for (int i = 0; i < 6; i++) step();

        // Long hold on bit 0: repeats every 20 cycles only with auto-repeat
        r_btn = 4'b0001;
        wait_pulse(4'b0001, k, p);
        check("long_first_pulse", p, 4'b0001);
        for (int i = 1; i <= 65; i++) begin
            step();
            check($sformatf("long_hold_t0+%0d", i), {3'b000, w_pulse[0]},
                  {3'b000, (c_AUTOREPEAT && (i % 20 == 0))});
        end
        check("long_level", w_level, 4'b0001);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
